// File: rtl/enqueue_arbiter.sv
// Round-robin enqueue arbiter for two byte channels feeding a shared queue.
// Per-transfer FSM: one-cycle enqueue strobe, ack held until the producer releases, timeout guard.
module enqueue_arbiter #(
   parameter int DATA_W  = 8,
   parameter int DEPTH   = 8,
   parameter int LEN_W   = 8,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 8
) (
   input  logic              clk_10KHz,
   input  logic              reset,
   input  logic              data_ready_a,
   input  logic [DATA_W-1:0] data_a,
   output logic              ack_a,
   input  logic              data_ready_b,
   input  logic [DATA_W-1:0] data_b,
   output logic              ack_b,
   input  logic [LEN_W-1:0]  len_in,
   output logic              enqueue_out,
   output logic [DATA_W-1:0] queue_data_out,
   output logic              owner_out,
   output logic              full_out,
   output logic              timeout_err,
   output logic [CNT_W-1:0]  count_a,
   output logic [CNT_W-1:0]  count_b
);

   localparam int TC_W = $clog2(TIMEOUT);
   localparam logic [TC_W-1:0] TC_LAST = TC_W'(TIMEOUT - 1);

   typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

   state_t             r_state;
   logic               r_enq;
   logic               r_ack_a;
   logic               r_ack_b;
   logic [DATA_W-1:0]  r_data;
   logic               r_owner;
   logic               r_terr;
   logic [CNT_W-1:0]   r_cnt_a;
   logic [CNT_W-1:0]   r_cnt_b;
   logic               r_blk_a;
   logic               r_blk_b;
   logic               r_rr;
   logic [TC_W-1:0]    r_tcnt;

   logic w_req_a;
   logic w_req_b;
   logic w_pick_b;
   logic w_grant;
   logic w_owner_ready;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
   endfunction

   assign full_out      = (len_in >= LEN_W'(DEPTH));
   assign w_req_a       = data_ready_a & ~r_blk_a;
   assign w_req_b       = data_ready_b & ~r_blk_b;
   assign w_grant       = (w_req_a | w_req_b) & ~full_out;
   assign w_owner_ready = r_owner ? data_ready_b : data_ready_a;

   // Winner selection: r_rr == 1 means channel B is preferred on contention.
   always_comb begin
      w_pick_b = 1'b0;
      if (w_req_a && w_req_b) begin
         w_pick_b = r_rr;
      end else begin
         w_pick_b = w_req_b;
      end
   end

   // Transfer FSM with registered handshake outputs, counters and error flags.
   always_ff @(posedge clk_10KHz) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_enq   <= 1'b0;
         r_ack_a <= 1'b0;
         r_ack_b <= 1'b0;
         r_data  <= '0;
         r_owner <= 1'b0;
         r_terr  <= 1'b0;
         r_cnt_a <= '0;
         r_cnt_b <= '0;
         r_blk_a <= 1'b0;
         r_blk_b <= 1'b0;
         r_rr    <= 1'b0;
         r_tcnt  <= '0;
      end else begin
         r_enq <= 1'b0;
         if (!data_ready_a) r_blk_a <= 1'b0;
         if (!data_ready_b) r_blk_b <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_grant) begin
                  r_enq   <= 1'b1;
                  r_owner <= w_pick_b;
                  r_data  <= w_pick_b ? data_b : data_a;
                  r_ack_a <= ~w_pick_b;
                  r_ack_b <= w_pick_b;
                  r_rr    <= ~w_pick_b;
                  if (w_pick_b) r_cnt_b <= sat_inc(r_cnt_b);
                  else          r_cnt_a <= sat_inc(r_cnt_a);
                  r_tcnt  <= '0;
                  r_state <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (!w_owner_ready) begin
                  r_ack_a <= 1'b0;
                  r_ack_b <= 1'b0;
                  r_state <= S_IDLE;
               end else if (r_tcnt == TC_LAST) begin
                  // Producer never released: block it until it drops data_ready once.
                  r_ack_a <= 1'b0;
                  r_ack_b <= 1'b0;
                  r_terr  <= 1'b1;
                  if (r_owner) r_blk_b <= 1'b1;
                  else         r_blk_a <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_tcnt <= r_tcnt + TC_W'(1);
               end
            end
            default: begin
               r_ack_a <= 1'b0;
               r_ack_b <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign enqueue_out    = r_enq;
   assign ack_a          = r_ack_a;
   assign ack_b          = r_ack_b;
   assign queue_data_out = r_data;
   assign owner_out      = r_owner;
   assign timeout_err    = r_terr;
   assign count_a        = r_cnt_a;
   assign count_b        = r_cnt_b;

endmodule

// File: tb/tb_enqueue_arbiter.sv
// Directed bench for enqueue_arbiter; a second instance with 2-bit counters checks saturation.
module tb_enqueue_arbiter;

   logic       clk_10KHz = 1'b0;
   logic       reset = 1'b0;
   logic       data_ready_a = 1'b0;
   logic [7:0] data_a = 8'h00;
   logic       data_ready_b = 1'b0;
   logic [7:0] data_b = 8'h00;
   logic [7:0] len_in = 8'd0;

   logic       ack_a, ack_b, enqueue_out, owner_out, full_out, timeout_err;
   logic [7:0] queue_data_out, count_a, count_b;

   logic       s_ack_a, s_ack_b, s_enq, s_owner, s_full, s_terr;
   logic [7:0] s_qd;
   logic [1:0] s_cnt_a, s_cnt_b;

   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;

   enqueue_arbiter #(.DATA_W(8), .DEPTH(8), .LEN_W(8), .TIMEOUT(16), .CNT_W(8)) u_dut (
      .clk_10KHz(clk_10KHz), .reset(reset),
      .data_ready_a(data_ready_a), .data_a(data_a), .ack_a(ack_a),
      .data_ready_b(data_ready_b), .data_b(data_b), .ack_b(ack_b),
      .len_in(len_in), .enqueue_out(enqueue_out), .queue_data_out(queue_data_out),
      .owner_out(owner_out), .full_out(full_out), .timeout_err(timeout_err),
      .count_a(count_a), .count_b(count_b)
   );

   enqueue_arbiter #(.DATA_W(8), .DEPTH(8), .LEN_W(8), .TIMEOUT(16), .CNT_W(2)) u_sat (
      .clk_10KHz(clk_10KHz), .reset(reset),
      .data_ready_a(data_ready_a), .data_a(data_a), .ack_a(s_ack_a),
      .data_ready_b(data_ready_b), .data_b(data_b), .ack_b(s_ack_b),
      .len_in(len_in), .enqueue_out(s_enq), .queue_data_out(s_qd),
      .owner_out(s_owner), .full_out(s_full), .timeout_err(s_terr),
      .count_a(s_cnt_a), .count_b(s_cnt_b)
   );

   always #5 clk_10KHz = ~clk_10KHz;

   always @(posedge clk_10KHz) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_10KHz);
      #1;
   endtask

   initial begin
      logic       exp_owner;
      logic [7:0] exp_data;
      int         last_cyc;

      tick();
      tick();
      check_eq("rst_enq",   enqueue_out, 0);
      check_eq("rst_ack_a", ack_a, 0);
      check_eq("rst_ack_b", ack_b, 0);
      check_eq("rst_qd",    queue_data_out, 0);
      check_eq("rst_owner", owner_out, 0);
      check_eq("rst_terr",  timeout_err, 0);
      check_eq("rst_cnt",   {count_a, count_b}, 0);
      reset = 1'b1;
      tick();

      // Single A byte
      data_ready_a = 1'b1; data_a = 8'h5A;
      tick();
      check_eq("a1_enq",   enqueue_out, 1);
      check_eq("a1_qd",    queue_data_out, 8'h5A);
      check_eq("a1_ack",   ack_a, 1);
      check_eq("a1_owner", owner_out, 0);
      check_eq("a1_cnt",   count_a, 1);
      tick();
      check_eq("a1_enq_off", enqueue_out, 0);
      check_eq("a1_ack_hold", ack_a, 1);
      data_ready_a = 1'b0;
      tick();
      check_eq("a1_ack_off", ack_a, 0);

      // Contention: pointer now prefers B, grants must alternate B,A,B,A...
      data_ready_a = 1'b1; data_a = 8'h10;
      data_ready_b = 1'b1; data_b = 8'h20;
      exp_owner = 1'b1;
      last_cyc = 0;
      for (int i = 0; i < 8; i++) begin
         exp_data = exp_owner ? data_b : data_a;
         tick();
         check_eq("ct_enq",   enqueue_out, 1);
         check_eq("ct_owner", owner_out, exp_owner);
         check_eq("ct_qd",    queue_data_out, exp_data);
         check_eq("ct_acks",  {ack_a, ack_b}, exp_owner ? 2'b01 : 2'b10);
         if (i > 0) check_eq("ct_gap", cyc - last_cyc, 3);
         last_cyc = cyc;
         tick();
         check_eq("ct_enq_off", enqueue_out, 0);
         if (exp_owner) data_ready_b = 1'b0; else data_ready_a = 1'b0;
         tick();
         check_eq("ct_ack_off", {ack_a, ack_b}, 2'b00);
         if (exp_owner) begin data_ready_b = 1'b1; data_b = data_b + 8'd1; end
         else           begin data_ready_a = 1'b1; data_a = data_a + 8'd1; end
         exp_owner = ~exp_owner;
      end
      data_ready_a = 1'b0; data_ready_b = 1'b0;
      tick();
      check_eq("ct_cnt_a", count_a, 5);
      check_eq("ct_cnt_b", count_b, 4);
      check_eq("sat_cnt_a", s_cnt_a, 3);
      check_eq("sat_cnt_b", s_cnt_b, 3);

      // Full: len 8 and 9 block, len 7 permits exactly one grant
      len_in = 8'd8; data_ready_b = 1'b1; data_b = 8'h77;
      tick(); tick();
      check_eq("full_enq",  enqueue_out, 0);
      check_eq("full_ack",  ack_b, 0);
      check_eq("full_flag", full_out, 1);
      len_in = 8'd9;
      tick();
      check_eq("full9_enq",  enqueue_out, 0);
      check_eq("full9_flag", full_out, 1);
      len_in = 8'd7;
      #1;
      check_eq("len7_flag", full_out, 0);
      tick();
      check_eq("len7_enq",   enqueue_out, 1);
      check_eq("len7_owner", owner_out, 1);
      check_eq("len7_qd",    queue_data_out, 8'h77);
      check_eq("len7_ack",   ack_b, 1);
      len_in = 8'd8;
      tick();
      data_ready_b = 1'b0;
      tick();
      check_eq("len7_ack_off", ack_b, 0);
      data_ready_b = 1'b1;
      tick(); tick();
      check_eq("len8_no_enq", enqueue_out, 0);
      check_eq("len8_cnt_b",  count_b, 5);
      data_ready_b = 1'b0; len_in = 8'd0;
      tick();

      // Timeout: A stuck high
      data_ready_a = 1'b1; data_a = 8'hC3;
      tick();
      check_eq("to_enq", enqueue_out, 1);
      check_eq("to_ack", ack_a, 1);
      for (int k = 0; k < 15; k++) tick();
      check_eq("to_ack_15",  ack_a, 1);
      check_eq("to_terr_15", timeout_err, 0);
      tick();
      check_eq("to_ack_16",  ack_a, 0);
      check_eq("to_terr_16", timeout_err, 1);
      for (int k = 0; k < 5; k++) begin
         tick();
         check_eq("to_blk_enq", enqueue_out, 0);
      end
      check_eq("to_cnt_a", count_a, 6);
      data_ready_a = 1'b0;
      tick();
      data_ready_a = 1'b1; data_a = 8'h3C;
      tick();
      check_eq("to_regrant", enqueue_out, 1);
      check_eq("to_qd",      queue_data_out, 8'h3C);
      check_eq("to_cnt_a2",  count_a, 7);
      check_eq("to_sticky",  timeout_err, 1);
      tick();
      data_ready_a = 1'b0;
      tick();

      // Reset mid-HOLD with B owning
      data_ready_b = 1'b1; data_b = 8'h99;
      tick();
      check_eq("rh_ack_b", ack_b, 1);
      tick();
      reset = 1'b0;
      tick();
      check_eq("rh_enq",   enqueue_out, 0);
      check_eq("rh_acks",  {ack_a, ack_b}, 2'b00);
      check_eq("rh_qd",    queue_data_out, 0);
      check_eq("rh_owner", owner_out, 0);
      check_eq("rh_terr",  timeout_err, 0);
      check_eq("rh_cnt",   {count_a, count_b}, 0);
      reset = 1'b1; data_ready_a = 1'b1; data_a = 8'hE1;
      tick();
      check_eq("rh_owner2", owner_out, 0);
      check_eq("rh_acks2",  {ack_a, ack_b}, 2'b10);
      check_eq("rh_qd2",    queue_data_out, 8'hE1);
      check_eq("rh_cnt_a",  count_a, 1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
